// File: rtl/mem_wb_if.sv
// mem_wb_if: bundles the MEM-side entry bus and the write-back-side head bus
// of the mem_wb_pipe stage. The slave modport is the pipeline register
// itself; the master modport is its surroundings (MEM stage driving entries,
// write-back stage driving out_ready).
interface mem_wb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // Entry presented by the MEM stage
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_mem_rdata;
    logic [AW-1:0] in_rd;
    logic          in_reg_write;
    logic          in_mem_to_reg;

    // Head entry offered to the register-file write port
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_alu_result;
    logic [DW-1:0] out_mem_rdata;
    logic [AW-1:0] out_rd;
    logic          out_reg_write;
    logic          out_mem_to_reg;
    logic [DW-1:0] out_wb_data;

    modport master (
        output in_valid,
        input  in_ready,
        output in_alu_result,
        output in_mem_rdata,
        output in_rd,
        output in_reg_write,
        output in_mem_to_reg,
        input  out_valid,
        output out_ready,
        input  out_alu_result,
        input  out_mem_rdata,
        input  out_rd,
        input  out_reg_write,
        input  out_mem_to_reg,
        input  out_wb_data
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_alu_result,
        input  in_mem_rdata,
        input  in_rd,
        input  in_reg_write,
        input  in_mem_to_reg,
        output out_valid,
        input  out_ready,
        output out_alu_result,
        output out_mem_rdata,
        output out_rd,
        output out_reg_write,
        output out_mem_to_reg,
        output out_wb_data
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM -> write-back pipeline register with a 2-entry skid
// buffer. in_ready is registered so a write-back stall never forms a
// combinational path back into MEM. The write-back data mux is evaluated at
// capture time and stored per entry.
// Optional performance counters (stall_cnt, drop_cnt) are built only when the
// macro MEM_WB_PERF_EN is defined.
module mem_wb_pipe #(
    parameter int DW             = 32,
    parameter int AW             = 5,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        flush,      // synchronous kill of all entries
    mem_wb_if.slave     bus
`ifdef MEM_WB_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [7:0]  drop_cnt
`endif
);

    // Occupancy and registered ready
    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic          in_ready_reg;

    // Head entry: drives the outputs
    logic [DW-1:0] head_alu_reg;
    logic [DW-1:0] head_rdata_reg;
    logic [AW-1:0] head_rd_reg;
    logic          head_rw_reg;
    logic          head_m2r_reg;
    logic [DW-1:0] head_wb_reg;

    // Skid entry: holds the second entry while the head is stalled
    logic [DW-1:0] skid_alu_reg;
    logic [DW-1:0] skid_rdata_reg;
    logic [AW-1:0] skid_rd_reg;
    logic          skid_rw_reg;
    logic          skid_m2r_reg;
    logic [DW-1:0] skid_wb_reg;

    // Handshake and steering
    logic          out_valid_int;
    logic          accept;
    logic          pop;
    logic          load_head_from_in;
    logic          load_head_from_skid;
    logic          load_skid;

    // Fields of the incoming entry as they will be stored
    logic          guard_hit;
    logic          cap_rw;
    logic [DW-1:0] cap_wb;

    // x0 write suppression: an entry targeting register 0 never writes
    generate
        if (ZERO_REG_GUARD != 0) begin : g_zero_guard
            assign guard_hit = (bus.in_rd == '0);
        end else begin : g_no_zero_guard
            assign guard_hit = 1'b0;
        end
    endgenerate

    // Capture-time field preparation: write enable and write-back data mux
    always_comb begin
        cap_rw = bus.in_reg_write && !guard_hit;
        cap_wb = bus.in_mem_to_reg ? bus.in_mem_rdata : bus.in_alu_result;
    end

    assign out_valid_int = (count_reg != 2'd0);

    // Handshake decode, occupancy update and entry steering
    always_comb begin
        accept              = bus.in_valid && in_ready_reg && !flush;
        pop                 = out_valid_int && bus.out_ready;
        count_next          = count_reg;
        load_head_from_in   = 1'b0;
        load_head_from_skid = 1'b0;
        load_skid           = 1'b0;

        if (flush) begin
            // Flush wins over everything; data registers simply hold
            count_next = 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
            // Empty stage, or a single head leaving as a new entry arrives:
            // the new entry goes straight into the head.
            load_head_from_in   = accept && ((count_reg == 2'd0) ||
                                             ((count_reg == 2'd1) && pop));
            // Full stage popping: the skid entry advances to the head
            load_head_from_skid = pop && (count_reg == 2'd2);
            // Head held with one entry: the arrival parks in the skid slot
            load_skid           = accept && (count_reg == 2'd1) && !pop;
        end
    end

    // Occupancy and ready registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b1;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next < 2'd2);
        end
    end

    // Head entry register: loaded from the input or from the skid slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_alu_reg   <= '0;
            head_rdata_reg <= '0;
            head_rd_reg    <= '0;
            head_rw_reg    <= 1'b0;
            head_m2r_reg   <= 1'b0;
            head_wb_reg    <= '0;
        end else if (load_head_from_in) begin
            head_alu_reg   <= bus.in_alu_result;
            head_rdata_reg <= bus.in_mem_rdata;
            head_rd_reg    <= bus.in_rd;
            head_rw_reg    <= cap_rw;
            head_m2r_reg   <= bus.in_mem_to_reg;
            head_wb_reg    <= cap_wb;
        end else if (load_head_from_skid) begin
            head_alu_reg   <= skid_alu_reg;
            head_rdata_reg <= skid_rdata_reg;
            head_rd_reg    <= skid_rd_reg;
            head_rw_reg    <= skid_rw_reg;
            head_m2r_reg   <= skid_m2r_reg;
            head_wb_reg    <= skid_wb_reg;
        end
    end

    // Skid entry register: only ever loaded from the input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_alu_reg   <= '0;
            skid_rdata_reg <= '0;
            skid_rd_reg    <= '0;
            skid_rw_reg    <= 1'b0;
            skid_m2r_reg   <= 1'b0;
            skid_wb_reg    <= '0;
        end else if (load_skid) begin
            skid_alu_reg   <= bus.in_alu_result;
            skid_rdata_reg <= bus.in_mem_rdata;
            skid_rd_reg    <= bus.in_rd;
            skid_rw_reg    <= cap_rw;
            skid_m2r_reg   <= bus.in_mem_to_reg;
            skid_wb_reg    <= cap_wb;
        end
    end

    // Outputs come straight from registers; only reg_write is gated so a
    // stale head can never write the register file.
    assign bus.in_ready       = in_ready_reg;
    assign bus.out_valid      = out_valid_int;
    assign bus.out_alu_result = head_alu_reg;
    assign bus.out_mem_rdata  = head_rdata_reg;
    assign bus.out_rd         = head_rd_reg;
    assign bus.out_reg_write  = head_rw_reg && out_valid_int;
    assign bus.out_mem_to_reg = head_m2r_reg;
    assign bus.out_wb_data    = head_wb_reg;

`ifdef MEM_WB_PERF_EN
    logic [15:0] stall_cnt_reg;
    logic [7:0]  drop_cnt_reg;

    // Saturating counters of write-back stalls and entry-dropping flushes;
    // flush itself does not clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 16'd0;
            drop_cnt_reg  <= 8'd0;
        end else begin
            if (out_valid_int && !bus.out_ready && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (flush && (count_reg != 2'd0) && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: scoreboard bench for mem_wb_pipe. Two instances receive the
// same stimulus, one with the x0 guard enabled and one without; accepted
// entries are pushed into per-instance queues and independent monitors pop
// and compare whenever an instance hands an entry to write-back.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
        logic [DW-1:0] wb;
        logic [AW-1:0] rd;
        logic          rw;
        logic          m2r;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    mem_wb_if #(.DW(DW), .AW(AW)) bus0 ();
    mem_wb_if #(.DW(DW), .AW(AW)) bus1 ();

`ifdef MEM_WB_PERF_EN
    logic [15:0] stall0, stall1;
    logic [7:0]  drop0, drop1;
`endif

    always #5 clk = ~clk;

    // Second instance mirrors the stimulus of the first
    assign bus1.in_valid      = bus0.in_valid;
    assign bus1.in_alu_result = bus0.in_alu_result;
    assign bus1.in_mem_rdata  = bus0.in_mem_rdata;
    assign bus1.in_rd         = bus0.in_rd;
    assign bus1.in_reg_write  = bus0.in_reg_write;
    assign bus1.in_mem_to_reg = bus0.in_mem_to_reg;
    assign bus1.out_ready     = bus0.out_ready;

    mem_wb_pipe #(.DW(DW), .AW(AW), .ZERO_REG_GUARD(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus0)
`ifdef MEM_WB_PERF_EN
        ,
        .stall_cnt (stall0),
        .drop_cnt  (drop0)
`endif
    );

    mem_wb_pipe #(.DW(DW), .AW(AW), .ZERO_REG_GUARD(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus1)
`ifdef MEM_WB_PERF_EN
        ,
        .stall_cnt (stall1),
        .drop_cnt  (drop1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_entry(input string tag, input exp_t e,
                                 input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                                 input logic [DW-1:0] wb, input logic [AW-1:0] rd,
                                 input logic rw, input logic m2r);
        $display("%s out: rd=%0d alu=%h rdata=%h wb=%h rw=%0d m2r=%0d", tag, rd, alu, rdata, wb, rw, m2r);
        check({tag, "_alu"},   64'(alu),   64'(e.alu));
        check({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
        check({tag, "_wb"},    64'(wb),    64'(e.wb));
        check({tag, "_rd"},    64'(rd),    64'(e.rd));
        check({tag, "_rw"},    64'(rw),    64'(e.rw));
        check({tag, "_m2r"},   64'(m2r),   64'(e.m2r));
    endtask

    // Expected response of each instance for an accepted entry
    task automatic push_exp(input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                            input logic [AW-1:0] rd, input logic rw, input logic m2r);
        exp_t e;
        e.alu   = alu;
        e.rdata = rdata;
        e.wb    = m2r ? rdata : alu;
        e.rd    = rd;
        e.m2r   = m2r;
        e.rw    = rw;
        q1.push_back(e);
        e.rw    = rw && (rd != '0);
        q0.push_back(e);
    endtask

    // Monitor for the guarded instance
    always @(negedge clk) begin
        if (reset) begin
            if (bus0.out_valid && bus0.out_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut0_unexpected: actual entry rd=%0d required none", bus0.out_rd);
                end else begin
                    compare_entry("dut0", q0.pop_front(), bus0.out_alu_result, bus0.out_mem_rdata,
                                  bus0.out_wb_data, bus0.out_rd, bus0.out_reg_write, bus0.out_mem_to_reg);
                end
            end else if (!bus0.out_valid) begin
                check("dut0_rw_gated", 64'(bus0.out_reg_write), 64'(0));
            end
        end
    end

    // Monitor for the unguarded instance
    always @(negedge clk) begin
        if (reset) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected: actual entry rd=%0d required none", bus1.out_rd);
                end else begin
                    compare_entry("dut1", q1.pop_front(), bus1.out_alu_result, bus1.out_mem_rdata,
                                  bus1.out_wb_data, bus1.out_rd, bus1.out_reg_write, bus1.out_mem_to_reg);
                end
            end else if (!bus1.out_valid) begin
                check("dut1_rw_gated", 64'(bus1.out_reg_write), 64'(0));
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // accepting edge with in_valid still asserted, so calls stream back-to-back.
    task automatic send(input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                        input logic [AW-1:0] rd, input logic rw, input logic m2r,
                        output int waits);
        bus0.in_valid      = 1'b1;
        bus0.in_alu_result = alu;
        bus0.in_mem_rdata  = rdata;
        bus0.in_rd         = rd;
        bus0.in_reg_write  = rw;
        bus0.in_mem_to_reg = m2r;
        waits = 0;
        while (!bus0.in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!bus0.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=0 after %0d cycles required 1", waits);
        end else begin
            $display("in: rd=%0d alu=%h rdata=%h rw=%0d m2r=%0d waits=%0d", rd, alu, rdata, rw, m2r, waits);
            push_exp(alu, rdata, rd, rw, m2r);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus0.in_valid      = 1'b0;
        bus0.in_alu_result = '0;
        bus0.in_mem_rdata  = '0;
        bus0.in_rd         = '0;
        bus0.in_reg_write  = 1'b0;
        bus0.in_mem_to_reg = 1'b0;
        bus0.out_ready     = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus0.out_valid), 64'(0));
        check("rst_in_ready",  64'(bus0.in_ready),  64'(1));
        check("rst_wb_data",   64'(bus0.out_wb_data), 64'(0));
        check("rst_rw",        64'(bus0.out_reg_write), 64'(0));
        check("rst_rd",        64'(bus0.out_rd), 64'(0));
        check("rst_alu",       64'(bus0.out_alu_result), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // Single load entry through an empty stage: 1-cycle latency
        bus0.out_ready = 1'b1;
        send(32'h0000_0010, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, w);
        bus0.in_valid = 1'b0;
        check("t1_valid", 64'(bus0.out_valid), 64'(1));
        check("t1_wb",    64'(bus0.out_wb_data), 64'h0000_0000_DEAD_BEEF);
        check("t1_rd",    64'(bus0.out_rd), 64'(5));
        tick(1);
        check("t1_drained", 64'(bus0.out_valid), 64'(0));
        tick(1);

        // Reset mid-stream with the stage full after 5 stalled cycles
        bus0.out_ready = 1'b0;
        send(32'h0000_0AAA, 32'h0000_0BBB, 5'd7, 1'b1, 1'b0, w);
        send(32'h0000_0CCC, 32'h0000_0DDD, 5'd8, 1'b1, 1'b1, w);
        bus0.in_valid = 1'b0;
        tick(4);
        check("t6_full_ready", 64'(bus0.in_ready), 64'(0));
        check("t6_full_valid", 64'(bus0.out_valid), 64'(1));
`ifdef MEM_WB_PERF_EN
        check("t6_stall_cnt", 64'(stall0), 64'(5));
`endif
        reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("t6_rst_valid", 64'(bus0.out_valid), 64'(0));
        check("t6_rst_ready", 64'(bus0.in_ready), 64'(1));
        check("t6_rst_wb",    64'(bus0.out_wb_data), 64'(0));
        check("t6_rst_rw",    64'(bus0.out_reg_write), 64'(0));
        check("t6_rst_rd",    64'(bus0.out_rd), 64'(0));
`ifdef MEM_WB_PERF_EN
        check("t6_rst_stall", 64'(stall0), 64'(0));
`endif
        @(negedge clk);
        reset = 1'b1;
        tick(1);

        // Back-pressure: A and B fill the stage, C waits, then all drain in order
        bus0.out_ready = 1'b0;
        send(32'h0000_0100, 32'h0000_1000, 5'd1, 1'b1, 1'b0, w);
        send(32'h0000_0200, 32'h0000_2000, 5'd2, 1'b1, 1'b1, w);
        check("t2_full_ready", 64'(bus0.in_ready), 64'(0));
        bus0.in_alu_result = 32'h0000_0300;
        bus0.in_mem_rdata  = 32'h0000_3000;
        bus0.in_rd         = 5'd3;
        tick(2);
        check("t2_held_ready", 64'(bus0.in_ready), 64'(0));
        check("t2_head_is_a",  64'(bus0.out_alu_result), 64'h100);
        bus0.out_ready = 1'b1;
        send(32'h0000_0300, 32'h0000_3000, 5'd3, 1'b0, 1'b1, w);
        bus0.in_valid = 1'b0;
        tick(3);

        // Streaming at full rate: accept and pop every cycle, no bubbles
        for (int i = 0; i < 10; i++) begin
            send(32'(i) * 32'h0101_0101, ~(32'(i) * 32'h0101_0101), 5'(i + 1),
                 i[0], i[1], w);
            check($sformatf("t3_no_wait_%0d", i), 64'(w), 64'(0));
            check($sformatf("t3_valid_%0d", i), 64'(bus0.out_valid), 64'(1));
        end
        bus0.in_valid = 1'b0;
        tick(2);

        // x0 destination: guarded instance suppresses the write
        send(32'h0000_0055, 32'h0000_00AA, 5'd0, 1'b1, 1'b0, w);
        bus0.in_valid = 1'b0;
        check("t4_valid",    64'(bus0.out_valid), 64'(1));
        check("t4_rw_guard", 64'(bus0.out_reg_write), 64'(0));
        check("t4_rw_open",  64'(bus1.out_reg_write), 64'(1));
        tick(2);

        // Flush a full stage while a new entry is offered
        bus0.out_ready = 1'b0;
        send(32'h0000_0D00, 32'h0000_D000, 5'd9, 1'b1, 1'b0, w);
        send(32'h0000_0E00, 32'h0000_E000, 5'd10, 1'b1, 1'b1, w);
        bus0.in_alu_result = 32'h0000_0F00;
        bus0.in_rd         = 5'd11;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        q0.delete();
        q1.delete();
        check("t5_valid", 64'(bus0.out_valid), 64'(0));
        check("t5_ready", 64'(bus0.in_ready), 64'(1));
        check("t5_rw",    64'(bus0.out_reg_write), 64'(0));
`ifdef MEM_WB_PERF_EN
        check("t5_drop_cnt", 64'(drop0), 64'(1));
`endif
        bus0.out_ready = 1'b1;
        tick(4);

        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
